// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
// The state encoding is fixed so the debug state output keeps its meaning between builds.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_DATA_W   = 32;
  localparam int ARB_MAX_WAIT = 15;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_IF_BUSY = 3'd1,
    ARB_DM_BUSY = 3'd2,
    ARB_IF_RESP = 3'd3,
    ARB_DM_RESP = 3'd4
  } arb_state_e;

  function automatic logic arb_is_busy(arb_state_e s);
    return (s == ARB_IF_BUSY) || (s == ARB_DM_BUSY);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating wait counter. Cleared on each grant and advanced on every busy cycle without mem_ready.
// last flags the enabled increment that lands on MAX_WAIT, so the caller aborts in that same cycle.
module mem_port_arbiter_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins in IDLE, the RESP states alternate the two sources, and grants are never preempted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flushF,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              memstallF,
  output logic              memstallM,
  output logic              mem_timeout,
  output arb_state_e        dbg_state
);

  // Handshake: a requester holds *_req (and its address/data) until it sees the one-cycle
  // *_valid pulse; if_req may also be withdrawn by flushF. The memory side sees a registered
  // mem_req held for the whole access and completes it in any cycle where mem_ready is high.

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              drop_q, drop_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic grant_if, grant_dm, busy, done, abort, wait_last;

  assign busy  = arb_is_busy(state_q);
  assign done  = busy && mem_ready;
  assign abort = busy && !mem_ready && wait_last;

  mem_port_arbiter_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (grant_if || grant_dm),
    .en      (busy && !mem_ready),
    .last    (wait_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dm_req) begin
          grant_dm = 1'b1;
          state_d  = ARB_DM_BUSY;
        end else if (if_req && !flushF) begin
          grant_if = 1'b1;
          state_d  = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY: if (done || abort) state_d = ARB_IF_RESP;
      ARB_DM_BUSY: if (done || abort) state_d = ARB_DM_RESP;
      // IF is never re-granted here, so a still-held fetch is not serviced twice.
      ARB_IF_RESP: begin
        if (dm_req) begin
          grant_dm = 1'b1;
          state_d  = ARB_DM_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_DM_RESP: begin
        if (if_req && !flushF) begin
          grant_if = 1'b1;
          state_d  = ARB_IF_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if_valid  = (state_q == ARB_IF_RESP) && !drop_q && !flushF;
    dm_valid  = (state_q == ARB_DM_RESP);
    memstallF = if_req && !if_valid && !flushF;
    memstallM = dm_req && !dm_valid;
    dbg_state = state_q;
  end

  always_comb begin
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    drop_d        = drop_q;
    mem_timeout_d = mem_timeout_q || abort;

    if (grant_dm) begin
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
    end else if (grant_if) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
    end else if (done || abort) begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end

    // A timed-out access returns zero data rather than whatever is on the bus.
    if (state_q == ARB_IF_BUSY && (done || abort)) begin
      if_rdata_d = done ? mem_rdata : '0;
    end
    if (state_q == ARB_DM_BUSY && (done || abort)) begin
      dm_rdata_d = done ? mem_rdata : '0;
    end

    // An in-flight fetch cannot be cancelled at the memory, so a flush only marks its data dead.
    if (state_q == ARB_IF_RESP) begin
      drop_d = 1'b0;
    end else if (state_q == ARB_IF_BUSY && flushF) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      drop_q        <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      drop_q        <= drop_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign mem_timeout = mem_timeout_q;

endmodule
